// File: rtl/scdaq_pkg.sv
// Shared types and constants for the scdaq readout path.
package scdaq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_HDR,
        ST_ADDR,
        ST_DATA,
        ST_DONE,
        ST_RELEASE
    } rdo_state_t;

    // Two-bit word tags in the top bits of every stream word
    localparam logic [1:0] TAG_HDR = 2'b11;
    localparam logic [1:0] TAG_SMP = 2'b00;

    localparam int OUT_W_DEF = 16;

endpackage

// File: rtl/scdaq_rdo_outreg.sv
// Output holding register for the readout stream: loads a word, keeps it
// stable until the downstream accepts it, or drops it on an explicit clear.
module scdaq_rdo_outreg
    import scdaq_pkg::*;
#(
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [OUT_W-1:0] load_data,
    input  logic             load_last,
    input  logic             clr,
    input  logic             m_ready,
    output logic [OUT_W-1:0] m_data,
    output logic             m_valid,
    output logic             m_last
);

    // Load wins; otherwise a handshake or clear retires the word (data kept)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data  <= '0;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
        end else if (load) begin
            m_data  <= load_data;
            m_valid <= 1'b1;
            m_last  <= load_last;
        end else if (clr || (m_valid && m_ready)) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
        end
    end

endmodule

// File: rtl/scdaq_rdo_ctrl.sv
// Frame readout controller: requests the acquisition buffer, walks every
// sample address with a fixed read latency, and streams header + samples.
module scdaq_rdo_ctrl
    import scdaq_pkg::*;
#(
    parameter int NSAMPLES     = 512,
    parameter int PRECISION    = 14,
    parameter int RDO_ADD_BLEN = 9,
    parameter int OUT_W        = OUT_W_DEF,
    parameter int RD_LAT       = 2,
    parameter int ACK_TIMEOUT  = 1023
) (
    input  logic                    RDO_Clock,
    input  logic                    Reset_n,
    input  logic                    Start,
    output logic                    Busy,
    output logic                    Err,
    output logic                    RDO_Req,
    input  logic                    RDO_Ack,
    output logic [RDO_ADD_BLEN-1:0] RDO_Add,
    input  logic [PRECISION-1:0]    RDO_Q,
    output logic                    RDO_Done,
    output logic [OUT_W-1:0]        M_Data,
    output logic                    M_Valid,
    input  logic                    M_Ready,
    output logic                    M_Last
);

    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

    rdo_state_t              state;
    logic [RDO_ADD_BLEN-1:0] idx;
    logic [2:0]              lat_cnt;
    logic [TMO_W-1:0]        tmo_cnt;
    logic [OUT_W-3:0]        frame_cnt;

    logic             hs, abort, lat_done, idx_last;
    logic             ol_load, ol_clr, ol_last;
    logic [OUT_W-1:0] ol_data;

    assign hs       = M_Valid && M_Ready;
    assign abort    = (state inside {ST_HDR, ST_ADDR, ST_DATA}) && !RDO_Ack;
    assign lat_done = (lat_cnt == 3'(RD_LAT - 1));
    assign idx_last = (idx == RDO_ADD_BLEN'(NSAMPLES - 1));

    // Decode what the output register loads this cycle; abort drops the word
    always_comb begin
        ol_load = 1'b0;
        ol_clr  = 1'b0;
        ol_last = 1'b0;
        ol_data = '0;
        case (state)
            ST_REQ: begin
                ol_load = RDO_Ack;
                ol_data = {TAG_HDR, frame_cnt};
            end
            ST_ADDR: begin
                ol_load = lat_done;
                ol_data = {TAG_SMP, (OUT_W-2)'(RDO_Q)};
                ol_last = idx_last;
            end
            default: ;
        endcase
        if (abort) begin
            ol_load = 1'b0;
            ol_clr  = 1'b1;
        end
    end

    // Readout FSM with its counters and registered control outputs
    always_ff @(posedge RDO_Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= ST_IDLE;
            idx       <= '0;
            lat_cnt   <= '0;
            tmo_cnt   <= '0;
            frame_cnt <= '0;
            RDO_Req   <= 1'b0;
            RDO_Done  <= 1'b0;
            RDO_Add   <= '0;
            Busy      <= 1'b0;
            Err       <= 1'b0;
        end else begin
            RDO_Done <= 1'b0;
            Err      <= 1'b0;
            if (abort) begin
                // Buffer withdrew its grant mid-frame: give up and release
                RDO_Req <= 1'b0;
                Err     <= 1'b1;
                state   <= ST_RELEASE;
            end else begin
                case (state)
                    ST_IDLE: if (Start) begin
                        state   <= ST_REQ;
                        RDO_Req <= 1'b1;
                        Busy    <= 1'b1;
                        tmo_cnt <= '0;
                    end
                    ST_REQ: begin
                        if (RDO_Ack) begin
                            state <= ST_HDR;
                        end else if (tmo_cnt == TMO_W'(ACK_TIMEOUT)) begin
                            state   <= ST_IDLE;
                            RDO_Req <= 1'b0;
                            Busy    <= 1'b0;
                            Err     <= 1'b1;
                        end else begin
                            tmo_cnt <= tmo_cnt + TMO_W'(1);
                        end
                    end
                    ST_HDR: if (hs) begin
                        state   <= ST_ADDR;
                        idx     <= '0;
                        RDO_Add <= '0;
                        lat_cnt <= '0;
                    end
                    ST_ADDR: begin
                        if (lat_done) state <= ST_DATA;
                        else          lat_cnt <= lat_cnt + 3'd1;
                    end
                    ST_DATA: if (hs) begin
                        if (idx_last) begin
                            state    <= ST_DONE;
                            RDO_Done <= 1'b1;
                            RDO_Req  <= 1'b0;
                        end else begin
                            state   <= ST_ADDR;
                            idx     <= idx + RDO_ADD_BLEN'(1);
                            RDO_Add <= idx + RDO_ADD_BLEN'(1);
                            lat_cnt <= '0;
                        end
                    end
                    ST_DONE: state <= ST_RELEASE;
                    ST_RELEASE: if (!RDO_Ack) begin
                        state     <= ST_IDLE;
                        Busy      <= 1'b0;
                        frame_cnt <= frame_cnt + (OUT_W-2)'(1);
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    scdaq_rdo_outreg #(.OUT_W(OUT_W)) u_outreg (
        .clk       (RDO_Clock),
        .rst_n     (Reset_n),
        .load      (ol_load),
        .load_data (ol_data),
        .load_last (ol_last),
        .clr       (ol_clr),
        .m_ready   (M_Ready),
        .m_data    (M_Data),
        .m_valid   (M_Valid),
        .m_last    (M_Last)
    );

endmodule
